ion_current_unit: RTL and testbench
===================================

ION_CURRENT_UNIT -- requirements
Module: ion_current_unit

Interface
REQ-001 Parameter W, 16, datapath width of all fixed-point operands and results (signed two's complement, FRAC fractional bits).
REQ-002 Parameter FRAC, 8, fractional bits; 1.0 encodes as 2^FRAC.
REQ-003 Parameter N_CH, 4, number of channel result slots; CH_W = clog2(N_CH).
REQ-004 Parameter P_MAX, 4, maximum gating exponent.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request; accepted only on a rising edge where busy=0.
REQ-008 ch_sel  input  CH_W  destination channel slot of the request.
REQ-009 exp_sel  input  3  gating exponent p.
REQ-010 gate  input  W  gating variable (0..1.0).
REQ-011 v_mem  input  W  membrane potential.
REQ-012 g_bar  input  W  maximal conductance.
REQ-013 e_rev  input  W  reversal potential.
REQ-014 busy  output  1  request in progress.
REQ-015 done  output  1  one-cycle pulse, result valid.
REQ-016 sat  output  1  saturation occurred in the last completed request.
REQ-017 i_out  output  W  result of the last completed request.
REQ-018 i_ch  output  N_CH*W  latest result per slot, slot c at bits [c*W +: W].

Function
REQ-019 Result SHALL be I = g_bar * gate^p * (v_mem - e_rev), computed sequentially with one W x W multiplier.
REQ-020 On acceptance (edge k) all inputs SHALL be latched; inputs are don't-care afterwards.
REQ-021 Latched gate SHALL be clamped to [0, 1.0]; negative -> 0, above 1.0 -> 1.0.
REQ-022 exp_sel=0 SHALL give gate^p = 1.0 (leak channel), timed as p=1; exp_sel > P_MAX SHALL be treated as P_MAX.
REQ-023 States: IDLE -> POW (p-1 cycles, skipped if p<=1) -> MUL_G (1 cycle, pow*g_bar) -> MUL_D (1 cycle, x diff) -> IDLE.
REQ-024 busy SHALL be 1 from edge k until the edge writing the result; done, i_out, i_ch slot, sat SHALL update on edge k+p+1 (p after REQ-022 mapping).
REQ-025 diff = v_mem - e_rev SHALL be computed at W+1 bits and saturated to W.
REQ-026 Each multiply: 2W-bit signed product, arithmetic right shift by FRAC (floor), saturate to [-2^(W-1), 2^(W-1)-1].
REQ-027 sat SHALL be the OR of all saturations within the request, cleared on acceptance of the next request.
REQ-028 start while busy=1 SHALL be ignored with no queuing; start on the done edge is ignored (busy still 1 before that edge).
REQ-029 Slots other than ch_sel SHALL hold their values.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, busy=0, done=0, sat=0, i_out=0, all i_ch slots=0.
REQ-031 Reset mid-request SHALL abort it with no done pulse; first start after rst release is accepted normally.

Verification (W=16, FRAC=8)
REQ-032 gate=0x0080, exp_sel=4, g_bar=0x2400, v_mem=0xBF00, e_rev=0xB300, ch_sel=1 -> done at k+5, i_out=0x1B00 (27.0), i_ch slot1=0x1B00, sat=0.
REQ-033 exp_sel=0, gate=0x0033, g_bar=0x0100, v_mem=0xBF00, e_rev=0xCA00, ch_sel=2 -> done at k+2, i_out=0xF500 (-11.0), sat=0.
REQ-034 gate=0x0100, exp_sel=1, g_bar=0x7800, v_mem=0x3200, e_rev=0xB300 -> i_out=0x7FFF, sat=1; next non-saturating request clears sat.
REQ-035 v_mem=0x7F00, e_rev=0x8000, gate=0x0100, exp_sel=1, g_bar=0x0100 -> diff saturates, i_out=0x7FFF, sat=1.
REQ-036 Second start pulsed two cycles after an exp_sel=4 acceptance -> ignored, exactly one done; gate=0x0180 -> clamped to 1.0, exp_sel=7 -> latency k+5.
REQ-037 rst asserted at k+2 of an exp_sel=4 request -> outputs zero immediately, no done; new request after release completes with correct latency.

Source files
------------

// File: rtl/ion_current_unit.sv
// Sequential ionic current unit: I = g_bar * gate^p * (v_mem - e_rev) using one
// shared W x W multiplier; the result is written to a per-channel slot.
module ion_current_unit #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int N_CH  = 4,
    parameter int P_MAX = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [2:0]        exp_sel,
    input  logic [W-1:0]      gate,
    input  logic [W-1:0]      v_mem,
    input  logic [W-1:0]      g_bar,
    input  logic [W-1:0]      e_rev,
    output logic              busy,
    output logic              done,
    output logic              sat,
    output logic [W-1:0]      i_out,
    output logic [N_CH*W-1:0] i_ch
);
    localparam logic [W-1:0] ONE  = W'(1) << FRAC;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, POW, MUL_G, MUL_D} state_t;

    state_t                   state;
    logic [2:0]               cnt;
    logic [W-1:0]             pow_r, gate_l, g_bar_l, diff_l;
    logic [CH_W-1:0]          ch_l;
    logic                     sat_acc;
    logic [N_CH-1:0][W-1:0]   slots;

    // Request-side preprocessing, consumed only on the accepting edge.
    logic [2:0]   p_eff;
    logic [W-1:0] gate_c, diff_c;
    logic [W:0]   diff_w;
    logic         diff_sat;

    always_comb begin
        p_eff = (int'(exp_sel) > P_MAX) ? 3'(P_MAX) : exp_sel;
        if (gate[W-1])
            gate_c = '0;
        else if (gate > ONE)
            gate_c = ONE;
        else
            gate_c = gate;
        diff_w   = {v_mem[W-1], v_mem} - {e_rev[W-1], e_rev};
        diff_sat = diff_w[W] != diff_w[W-1];
        diff_c   = diff_sat ? (diff_w[W] ? MINV : MAXV) : diff_w[W-1:0];
    end

    // Shared multiplier: pow_r is always the left operand, the right one follows the state.
    logic [W-1:0]          mul_b, mul_res;
    logic signed [2*W-1:0] prod, shifted;
    logic                  mul_sat;

    always_comb begin
        case (state)
            POW:     mul_b = gate_l;
            MUL_G:   mul_b = g_bar_l;
            default: mul_b = diff_l;
        endcase
        prod    = $signed(pow_r) * $signed(mul_b);
        shifted = prod >>> FRAC;
        mul_sat = !((&shifted[2*W-1:W-1]) || !(|shifted[2*W-1:W-1]));
        mul_res = mul_sat ? (shifted[2*W-1] ? MINV : MAXV) : shifted[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pow_r   <= '0;
            gate_l  <= '0;
            g_bar_l <= '0;
            diff_l  <= '0;
            ch_l    <= '0;
            sat_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            i_out   <= '0;
            slots   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    gate_l  <= gate_c;
                    g_bar_l <= g_bar;
                    diff_l  <= diff_c;
                    ch_l    <= ch_sel;
                    sat_acc <= diff_sat;
                    sat     <= 1'b0;
                    busy    <= 1'b1;
                    pow_r   <= (p_eff == 3'd0) ? ONE : gate_c;
                    if (p_eff >= 3'd2) begin
                        cnt   <= p_eff - 3'd2;
                        state <= POW;
                    end else begin
                        state <= MUL_G;
                    end
                end
                POW: begin
                    pow_r   <= mul_res;
                    sat_acc <= sat_acc | mul_sat;
                    if (cnt == 3'd0)
                        state <= MUL_G;
                    else
                        cnt <= cnt - 3'd1;
                end
                MUL_G: begin
                    pow_r   <= mul_res;
                    sat_acc <= sat_acc | mul_sat;
                    state   <= MUL_D;
                end
                default: begin
                    i_out <= mul_res;
                    if (int'(ch_l) < N_CH)
                        slots[ch_l] <= mul_res;
                    sat   <= sat_acc | mul_sat;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign i_ch = slots;

endmodule

// File: tb/tb_ion_current_unit.sv
// Directed-vector bench for ion_current_unit (W=16, FRAC=8, N_CH=4).
module tb_ion_current_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ch_sel = '0;
    logic [2:0]  exp_sel = '0;
    logic [15:0] gate = '0, v_mem = '0, g_bar = '0, e_rev = '0;
    logic        busy, done, sat;
    logic [15:0] i_out;
    logic [63:0] i_ch;

    ion_current_unit #(.W(16), .FRAC(8), .N_CH(4), .P_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .exp_sel(exp_sel),
        .gate(gate), .v_mem(v_mem), .g_bar(g_bar), .e_rev(e_rev),
        .busy(busy), .done(done), .sat(sat), .i_out(i_out), .i_ch(i_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] gate;
        logic [2:0]  exp_sel;
        logic [15:0] g_bar, v_mem, e_rev;
        logic [1:0]  ch;
        int          lat;
        logic [15:0] i_exp;
        logic        sat_exp;
    } vec_t;

    vec_t        tbl[9];
    logic [63:0] model_ch = '0;
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        gate = v.gate; exp_sel = v.exp_sel; g_bar = v.g_bar;
        v_mem = v.v_mem; e_rev = v.e_rev; ch_sel = v.ch;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d busy_on_accept", idx), busy, 1);
        chk($sformatf("v%0d sat_cleared", idx), sat, 0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); lat++; #1;
            if (done) break;
        end
        model_ch[v.ch*16 +: 16] = v.i_exp;
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d i_out", idx), i_out, v.i_exp);
        chk($sformatf("v%0d sat", idx), sat, v.sat_exp);
        chk($sformatf("v%0d i_ch", idx), i_ch, model_ch);
        chk($sformatf("v%0d busy_off", idx), busy, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d done_pulse", idx), done, 0);
    endtask

    initial begin
        vec_t v36, spur;
        int   ndone, lat;
        logic [15:0] first_out;

        //            gate     p     g_bar    v_mem    e_rev    ch lat  i_exp    sat
        tbl[0] = '{16'h0080, 3'd4, 16'h2400, 16'hBF00, 16'hB300, 2'd1, 5, 16'h1B00, 1'b0};
        tbl[1] = '{16'h0033, 3'd0, 16'h0100, 16'hBF00, 16'hCA00, 2'd2, 2, 16'hF500, 1'b0};
        tbl[2] = '{16'h0100, 3'd1, 16'h7800, 16'h3200, 16'hB300, 2'd0, 2, 16'h7FFF, 1'b1};
        tbl[3] = '{16'h0080, 3'd1, 16'h0200, 16'h0300, 16'h0100, 2'd3, 2, 16'h0200, 1'b0};
        tbl[4] = '{16'h0100, 3'd1, 16'h0100, 16'h7F00, 16'h8000, 2'd0, 2, 16'h7FFF, 1'b1};
        tbl[5] = '{16'hFF00, 3'd2, 16'h0100, 16'h0100, 16'h0000, 2'd3, 3, 16'h0000, 1'b0};
        tbl[6] = '{16'h00C0, 3'd3, 16'h0400, 16'h0200, 16'h0400, 2'd2, 4, 16'hFCA0, 1'b0};
        tbl[7] = '{16'h0100, 3'd1, 16'h0001, 16'hFF00, 16'h0000, 2'd1, 2, 16'hFFFF, 1'b0};
        tbl[8] = '{16'h0100, 3'd1, 16'h7800, 16'hB300, 16'h3200, 2'd0, 2, 16'h8000, 1'b1};
        v36    = '{16'h0180, 3'd7, 16'h0100, 16'h0500, 16'h0000, 2'd3, 5, 16'h0500, 1'b0};
        spur   = '{16'h0100, 3'd1, 16'h0100, 16'h0900, 16'h0000, 2'd0, 2, 16'h0900, 1'b0};

        // Reset state
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sat", sat, 0);
        chk("rst i_out", i_out, 0);
        chk("rst i_ch", i_ch, 0);
        @(negedge clk); rst = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Starts at k+2 (busy) and on the done edge k+5 are both dropped.
        @(negedge clk);
        drive(v36); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; lat = 0; first_out = '0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 2 || j == 5) begin drive(spur); start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = j; first_out = i_out; end
            end
        end
        start = 1'b0;
        model_ch[v36.ch*16 +: 16] = v36.i_exp;
        chk("ignore ndone", ndone, 1);
        chk("ignore latency", lat, v36.lat);
        chk("ignore i_out", first_out, v36.i_exp);
        chk("ignore i_ch", i_ch, model_ch);

        // Reset two edges into an exp_sel=4 request
        @(negedge clk);
        drive(tbl[0]); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort i_out", i_out, 0);
        chk("abort i_ch", i_ch, 0);
        chk("abort sat", sat, 0);
        ndone = 0;
        repeat (6) begin @(posedge clk); #1; if (done) ndone++; end
        chk("abort no_done", ndone, 0);
        model_ch = '0;
        @(negedge clk); rst = 1'b1;
        apply(tbl[0], 100);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
